// File: rtl/rv32_pkg.sv
// Shared constants for the OF-stage forwarding / hazard unit.
// Stall vector layout, NOP encoding and default parameters.
package rv32_pkg;

    localparam int NUM_SRC_DEF    = 2;
    localparam int NUM_STAGES_DEF = 3;
    localparam int XLEN_DEF       = 32;
    localparam int MAX_LD_DEF     = 4;
    localparam int CNT_W_DEF      = 16;

    localparam int STALL_W     = 5;
    localparam int STALL_IF    = 0;
    localparam int STALL_IFOF  = 1;
    localparam int STALL_OFEX  = 2;
    localparam int STALL_EXMEM = 3;
    localparam int STALL_MEMWB = 4;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef logic [4:0] reg_idx_t;

    function automatic logic [STALL_W-1:0] stall_vec(
        input logic hz,
        input logic imem_rdy,
        input logic dmem_rdy
    );
        logic [STALL_W-1:0] v;
        v              = '0;
        v[STALL_IF]    = hz | ~dmem_rdy;
        v[STALL_IFOF]  = hz | ~dmem_rdy | ~imem_rdy;
        v[STALL_OFEX]  = ~dmem_rdy;
        v[STALL_EXMEM] = ~dmem_rdy;
        v[STALL_MEMWB] = ~dmem_rdy;
        return v;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Bundle between the pipeline and the forwarding / hazard unit.
// master = pipeline side, slave = hazard unit.
interface fwd_hazard_unit_if #(
    parameter int NUM_SRC    = rv32_pkg::NUM_SRC_DEF,
    parameter int NUM_STAGES = rv32_pkg::NUM_STAGES_DEF,
    parameter int XLEN       = rv32_pkg::XLEN_DEF,
    parameter int CNT_W      = rv32_pkg::CNT_W_DEF
) ();
    logic                             imem_ready;
    logic                             dmem_ready;
    logic                             of_valid;
    logic [NUM_SRC-1:0][4:0]          of_src_addr;
    logic [NUM_SRC-1:0]               of_src_used;
    logic [NUM_STAGES-1:0]            stg_wb_en;
    logic [NUM_STAGES-1:0][4:0]       stg_wb_addr;
    logic [NUM_STAGES-1:0][XLEN-1:0]  stg_wb_data;
    logic [NUM_STAGES-1:0]            stg_data_ready;
    logic                             ld_issue;
    logic [4:0]                       ld_issue_rd;
    logic                             ld_done;
    logic [4:0]                       ld_done_rd;
    logic [NUM_SRC-1:0][XLEN-1:0]     fwd_data;
    logic [NUM_SRC-1:0]               fwd_en;
    logic [4:0]                       stall;
    logic                             ld_credit_ok;
    logic [CNT_W-1:0]                 hazard_stall_cnt;
    logic                             sb_err;

    modport master (
        output imem_ready, dmem_ready, of_valid, of_src_addr, of_src_used,
        output stg_wb_en, stg_wb_addr, stg_wb_data, stg_data_ready,
        output ld_issue, ld_issue_rd, ld_done, ld_done_rd,
        input  fwd_data, fwd_en, stall, ld_credit_ok, hazard_stall_cnt, sb_err
    );

    modport slave (
        input  imem_ready, dmem_ready, of_valid, of_src_addr, of_src_used,
        input  stg_wb_en, stg_wb_addr, stg_wb_data, stg_data_ready,
        input  ld_issue, ld_issue_rd, ld_done, ld_done_rd,
        output fwd_data, fwd_en, stall, ld_credit_ok, hazard_stall_cnt, sb_err
    );
endinterface

// File: rtl/ld_scoreboard.sv
// Outstanding-load scoreboard: per-register pending bits plus
// an in-flight counter with credit output and sticky error.
module ld_scoreboard #(
    parameter int MAX_LD = rv32_pkg::MAX_LD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_issue,
    input  logic [4:0]  i_issue_rd,
    input  logic        i_done,
    input  logic [4:0]  i_done_rd,
    output logic [31:0] o_pending,
    output logic        o_credit_ok,
    output logic        o_err
);
    localparam int CW = $clog2(MAX_LD) + 1;

    logic [CW-1:0] r_cnt;
    logic [31:0]   r_pending;
    logic          r_err;
    logic [31:0]   w_pend_nxt;
    logic          w_full;
    logic          w_empty;
    logic          w_ovf;
    logic          w_unf;

    assign w_full  = (r_cnt == CW'(MAX_LD));
    assign w_empty = (r_cnt == '0);
    assign w_ovf   = i_issue & ~i_done & w_full;
    assign w_unf   = i_done & ~i_issue & w_empty;

    // clear on return first, then set on accepted issue so issue wins
    always_comb begin
        w_pend_nxt = r_pending;
        if (i_done)
            w_pend_nxt[i_done_rd] = 1'b0;
        if (i_issue && !w_ovf && i_issue_rd != 5'd0)
            w_pend_nxt[i_issue_rd] = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    // counter, pending bits and sticky over/underflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            if (i_issue && !i_done && !w_full)
                r_cnt <= r_cnt + CW'(1);
            else if (i_done && !i_issue && !w_empty)
                r_cnt <= r_cnt - CW'(1);
            if (w_ovf || w_unf)
                r_err <= 1'b1;
            r_pending <= w_pend_nxt;
        end
    end

    assign o_pending   = r_pending;
    assign o_credit_ok = (r_cnt < CW'(MAX_LD));
    assign o_err       = r_err;
endmodule

// File: rtl/fwd_hazard_unit.sv
// OF-stage operand forwarding with youngest-stage priority,
// load-use hazard detection and pipeline stall generation.
module fwd_hazard_unit
    import rv32_pkg::*;
#(
    parameter int NUM_SRC    = NUM_SRC_DEF,
    parameter int NUM_STAGES = NUM_STAGES_DEF,
    parameter int XLEN       = XLEN_DEF,
    parameter int MAX_LD     = MAX_LD_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input logic              clk,
    input logic              reset,
    fwd_hazard_unit_if.slave bus
);
    logic [31:0]                  w_pending;
    logic [NUM_SRC-1:0]           w_hit;
    logic [NUM_SRC-1:0]           w_src_hz;
    logic [NUM_SRC-1:0][XLEN-1:0] w_win_data;
    logic                         w_hz;
    logic [NUM_SRC-1:0]           r_fwd_en;
    logic [NUM_SRC-1:0][XLEN-1:0] r_fwd_data;
    logic [CNT_W-1:0]             r_hz_cnt;

    ld_scoreboard #(.MAX_LD(MAX_LD)) u_sb (
        .clk         (clk),
        .reset       (reset),
        .i_issue     (bus.ld_issue),
        .i_issue_rd  (bus.ld_issue_rd),
        .i_done      (bus.ld_done),
        .i_done_rd   (bus.ld_done_rd),
        .o_pending   (w_pending),
        .o_credit_ok (bus.ld_credit_ok),
        .o_err       (bus.sb_err)
    );

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [NUM_STAGES-1:0] w_match;
        logic                  w_hit_l;
        logic                  w_rdy_l;
        logic [XLEN-1:0]       w_data_l;
        logic [4:0]            w_addr;

        assign w_addr = bus.of_src_addr[s];

        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stg
            assign w_match[k] = bus.of_valid & bus.of_src_used[s]
                              & bus.stg_wb_en[k]
                              & (bus.stg_wb_addr[k] == w_addr)
                              & (w_addr != 5'd0);
        end

        // scan oldest-first so the youngest matching stage wins
        always_comb begin
            w_hit_l  = 1'b0;
            w_rdy_l  = 1'b1;
            w_data_l = '0;
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (w_match[k]) begin
                    w_hit_l  = 1'b1;
                    w_rdy_l  = bus.stg_data_ready[k];
                    w_data_l = bus.stg_wb_data[k];
                end
            end
        end

        assign w_hit[s]      = w_hit_l;
        assign w_win_data[s] = w_data_l;
        assign w_src_hz[s]   = w_hit_l ? ~w_rdy_l
                             : (bus.of_valid & bus.of_src_used[s]
                                & w_pending[w_addr]);
    end

    assign w_hz      = |w_src_hz;
    assign bus.stall = stall_vec(w_hz, bus.imem_ready, bus.dmem_ready);

    // forwarding registers: frozen on dmem stall, bubble on hazard
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fwd_en   <= '0;
            r_fwd_data <= '0;
        end else if (bus.dmem_ready) begin
            if (w_hz) begin
                r_fwd_en <= '0;
            end else begin
                r_fwd_en <= w_hit;
                for (int s = 0; s < NUM_SRC; s++)
                    if (w_hit[s])
                        r_fwd_data[s] <= w_win_data[s];
            end
        end
    end

    // saturating count of cycles lost to data hazards
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_hz_cnt <= '0;
        else if (w_hz && bus.dmem_ready && !(&r_hz_cnt))
            r_hz_cnt <= r_hz_cnt + CNT_W'(1);
    end

    assign bus.fwd_en           = r_fwd_en;
    assign bus.fwd_data         = r_fwd_data;
    assign bus.hazard_stall_cnt = r_hz_cnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed cases then random traffic
// checked against a behavioural model of the forwarding rules.
module tb_fwd_hazard_unit;
    import rv32_pkg::*;

    localparam int NS  = 2;
    localparam int NST = 3;
    localparam int XL  = 32;
    localparam int ML  = 4;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.NUM_SRC(NS), .NUM_STAGES(NST), .XLEN(XL), .CNT_W(CW)) bus ();

    fwd_hazard_unit #(
        .NUM_SRC(NS), .NUM_STAGES(NST), .XLEN(XL), .MAX_LD(ML), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    bit          m_pend[32];
    int          m_cnt;
    bit          m_err;
    int          m_hcnt;
    bit          m_fe[NS];
    logic [XL-1:0] m_fd[NS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_cnt  = 0;
        m_err  = 1'b0;
        m_hcnt = 0;
        for (int s = 0; s < NS; s++) begin
            m_fe[s] = 1'b0;
            m_fd[s] = '0;
        end
    endtask

    task automatic idle();
        bus.imem_ready  = 1'b1;
        bus.dmem_ready  = 1'b1;
        bus.of_valid    = 1'b0;
        bus.of_src_addr = '0;
        bus.of_src_used = '0;
        bus.stg_wb_en   = '0;
        bus.stg_wb_addr = '0;
        bus.stg_wb_data = '0;
        bus.stg_data_ready = '1;
        bus.ld_issue    = 1'b0;
        bus.ld_issue_rd = '0;
        bus.ld_done     = 1'b0;
        bus.ld_done_rd  = '0;
    endtask

    // youngest stage writing the same nonzero register wins
    function automatic void winner(input int s, output bit hit,
                                   output bit rdy, output logic [XL-1:0] d);
        int a;
        hit = 1'b0; rdy = 1'b1; d = '0;
        a = int'(bus.of_src_addr[s]);
        if (!bus.of_valid || !bus.of_src_used[s] || a == 0) return;
        for (int k = 0; k < NST; k++) begin
            if (bus.stg_wb_en[k] && int'(bus.stg_wb_addr[k]) == a) begin
                hit = 1'b1;
                rdy = bus.stg_data_ready[k];
                d   = bus.stg_wb_data[k];
                return;
            end
        end
    endfunction

    function automatic bit ref_hz();
        bit h, r, any;
        logic [XL-1:0] d;
        any = 1'b0;
        for (int s = 0; s < NS; s++) begin
            winner(s, h, r, d);
            if (h && !r) any = 1'b1;
            if (!h && bus.of_valid && bus.of_src_used[s]
                && m_pend[int'(bus.of_src_addr[s])]) any = 1'b1;
        end
        return any;
    endfunction

    // one clock: check comb outputs, advance model, check registered outputs
    task automatic cyc();
        bit hz, dm, im, h, r;
        logic [XL-1:0] d;
        logic [4:0] est;
        int ir, dr;
        #2;
        hz = ref_hz();
        dm = bus.dmem_ready;
        im = bus.imem_ready;
        est = {!dm, !dm, !dm, hz || !dm || !im, hz || !dm};
        chk("stall", bus.stall, est);
        chk("credit", bus.ld_credit_ok, m_cnt < ML);
        @(posedge clk);
        if (dm) begin
            for (int s = 0; s < NS; s++) begin
                winner(s, h, r, d);
                if (hz) m_fe[s] = 1'b0;
                else begin
                    m_fe[s] = h;
                    if (h) m_fd[s] = d;
                end
            end
            if (hz && m_hcnt < (1 << CW) - 1) m_hcnt++;
        end
        ir = int'(bus.ld_issue_rd);
        dr = int'(bus.ld_done_rd);
        if (bus.ld_issue && !bus.ld_done) begin
            if (m_cnt == ML) m_err = 1'b1;
            else begin
                m_cnt++;
                m_pend[ir] = 1'b1;
            end
        end else if (bus.ld_done && !bus.ld_issue) begin
            if (m_cnt == 0) m_err = 1'b1;
            else m_cnt--;
            m_pend[dr] = 1'b0;
        end else if (bus.ld_done && bus.ld_issue) begin
            m_pend[dr] = 1'b0;
            m_pend[ir] = 1'b1;
        end
        m_pend[0] = 1'b0;
        #1;
        for (int s = 0; s < NS; s++) begin
            chk($sformatf("fwd_en%0d", s), bus.fwd_en[s], m_fe[s]);
            chk($sformatf("fwd_data%0d", s), bus.fwd_data[s], m_fd[s]);
        end
        chk("hz_cnt", bus.hazard_stall_cnt, m_hcnt);
        chk("sb_err", bus.sb_err, m_err);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_fwd_en", bus.fwd_en, 0);
        chk("rst_fwd_data", bus.fwd_data, 0);
        chk("rst_hz_cnt", bus.hazard_stall_cnt, 0);
        chk("rst_sb_err", bus.sb_err, 0);
        chk("rst_credit", bus.ld_credit_ok, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int h0;
        reset = 1'b1;
        idle();
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_fwd_en", bus.fwd_en, 0);
        chk("reset_stall", bus.stall, 0);
        chk("reset_credit", bus.ld_credit_ok, 1);
        reset = 1'b0;

        // youngest of two matching stages forwards
        bus.of_valid = 1'b1;
        bus.of_src_addr[0] = 5'd5; bus.of_src_used[0] = 1'b1;
        bus.stg_wb_en[1] = 1'b1; bus.stg_wb_addr[1] = 5'd5; bus.stg_wb_data[1] = 32'hAA;
        bus.stg_wb_en[2] = 1'b1; bus.stg_wb_addr[2] = 5'd5; bus.stg_wb_data[2] = 32'hBB;
        cyc();
        chk("prio_en", bus.fwd_en[0], 1);
        chk("prio_data", bus.fwd_data[0], 32'hAA);

        // x0 never forwards or stalls
        idle();
        bus.of_valid = 1'b1; bus.of_src_used = '1;
        bus.stg_wb_en = '1;
        bus.stg_wb_data = {32'h1, 32'h2, 32'h3};
        cyc();
        chk("x0_en", bus.fwd_en, 0);
        chk("x0_stall", bus.stall, 0);

        // producer result not ready -> bubble and count
        idle();
        bus.of_valid = 1'b1;
        bus.of_src_addr[1] = 5'd7; bus.of_src_used[1] = 1'b1;
        bus.stg_wb_en[0] = 1'b1; bus.stg_wb_addr[0] = 5'd7;
        bus.stg_data_ready[0] = 1'b0;
        h0 = m_hcnt;
        cyc();
        chk("ldu_stall", bus.stall[1:0], 2'b11);
        chk("ldu_en", bus.fwd_en, 0);
        chk("ldu_cnt", bus.hazard_stall_cnt, h0 + 1);

        // scoreboard hazard until the load returns
        idle();
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd9;
        cyc();
        idle();
        bus.of_valid = 1'b1;
        bus.of_src_addr[0] = 5'd9; bus.of_src_used[0] = 1'b1;
        repeat (3) cyc();
        chk("sb_hz", bus.stall[0], 1);
        bus.ld_done = 1'b1; bus.ld_done_rd = 5'd9;
        cyc();
        bus.ld_done = 1'b0;
        cyc();
        chk("sb_clear", bus.stall, 0);

        // fill load credits, overflow, then drain one
        idle();
        for (int i = 0; i < ML; i++) begin
            bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'(10 + i);
            cyc();
        end
        chk("credit_full", bus.ld_credit_ok, 0);
        bus.ld_issue_rd = 5'd20;
        cyc();
        chk("ovf_err", bus.sb_err, 1);
        bus.ld_issue = 1'b0;
        bus.ld_done = 1'b1; bus.ld_done_rd = 5'd10;
        cyc();
        chk("drain_credit", bus.ld_credit_ok, 1);
        bus.ld_done = 1'b0;
        bus.of_valid = 1'b1;
        bus.of_src_addr[0] = 5'd11; bus.of_src_used[0] = 1'b1;
        cyc();
        do_reset();
        idle();
        bus.of_valid = 1'b1;
        bus.of_src_addr[0] = 5'd11; bus.of_src_used[0] = 1'b1;
        cyc();
        chk("rst_pend", bus.stall, 0);

        // dmem stall freezes everything
        idle();
        bus.of_valid = 1'b1;
        bus.of_src_addr[0] = 5'd3; bus.of_src_used[0] = 1'b1;
        bus.stg_wb_en[2] = 1'b1; bus.stg_wb_addr[2] = 5'd3; bus.stg_wb_data[2] = 32'h1234;
        cyc();
        bus.dmem_ready = 1'b0;
        bus.stg_wb_data[2] = 32'h5678;
        cyc();
        chk("dm_stall", bus.stall, 5'h1F);
        chk("dm_hold", bus.fwd_data[0], 32'h1234);

        // hazard counter saturates
        idle();
        bus.of_valid = 1'b1;
        bus.of_src_addr[0] = 5'd4; bus.of_src_used[0] = 1'b1;
        bus.stg_wb_en[1] = 1'b1; bus.stg_wb_addr[1] = 5'd4;
        bus.stg_data_ready[1] = 1'b0;
        repeat (20) cyc();
        chk("sat_cnt", bus.hazard_stall_cnt, (1 << CW) - 1);
        do_reset();

        // random traffic
        for (int n = 0; n < 300; n++) begin
            bus.imem_ready = ($urandom_range(3) != 0);
            bus.dmem_ready = ($urandom_range(7) != 0);
            bus.of_valid   = ($urandom_range(7) != 0);
            for (int s = 0; s < NS; s++) begin
                bus.of_src_addr[s] = 5'($urandom_range(7));
                bus.of_src_used[s] = ($urandom_range(3) != 0);
            end
            for (int k = 0; k < NST; k++) begin
                bus.stg_wb_en[k]      = $urandom_range(1);
                bus.stg_wb_addr[k]    = 5'($urandom_range(7));
                bus.stg_wb_data[k]    = $urandom;
                bus.stg_data_ready[k] = ($urandom_range(3) != 0);
            end
            bus.ld_issue    = ($urandom_range(3) == 0);
            bus.ld_issue_rd = 5'($urandom_range(7));
            bus.ld_done     = ($urandom_range(3) == 0);
            bus.ld_done_rd  = 5'($urandom_range(7));
            cyc();
            if (n == 150) do_reset();
        end

        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit
Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, number of OF-stage source operands (2..3).
REQ-002 SHALL have parameter NUM_STAGES, default 3, number of producer stages; index 0 is youngest (EX out), NUM_STAGES-1 oldest (WB out).
REQ-003 SHALL have parameter XLEN, default 32, data width.
REQ-004 SHALL have parameter MAX_LD, default 4, max outstanding loads (power of 2).
REQ-005 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-006 SHALL have port clk  in  1  single clock, rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port imem_ready  in  1  instruction memory ready.
REQ-009 SHALL have port dmem_ready  in  1  data memory ready.
REQ-010 SHALL have port of_valid  in  1  OF-stage instruction valid and forwardable.
REQ-011 SHALL have port of_src_addr  in  NUM_SRC x 5  OF source register indices.
REQ-012 SHALL have port of_src_used  in  NUM_SRC  per-source read-enable.
REQ-013 SHALL have port stg_wb_en  in  NUM_STAGES  stage holds valid register write.
REQ-014 SHALL have port stg_wb_addr  in  NUM_STAGES x 5  stage destination register.
REQ-015 SHALL have port stg_wb_data  in  NUM_STAGES x XLEN  stage result.
REQ-016 SHALL have port stg_data_ready  in  NUM_STAGES  result available (0 for load still in flight).
REQ-017 SHALL have port ld_issue / ld_issue_rd  in  1 / 5  load accepted by dmem, its destination.
REQ-018 SHALL have port ld_done / ld_done_rd  in  1 / 5  load data returned, its destination.
REQ-019 SHALL have port fwd_data / fwd_en  out  NUM_SRC x XLEN / NUM_SRC  registered forwarding value and select.
REQ-020 SHALL have port stall  out  5  {memwb, exmem, ofex, ifof, if} stall vector, combinational.
REQ-021 SHALL have port ld_credit_ok / hazard_stall_cnt / sb_err  out  1 / CNT_W / 1  load credit, saturating hazard-stall count, sticky scoreboard error.
Function
REQ-022 Per source s, match[k] SHALL = of_valid & of_src_used[s] & stg_wb_en[k] & (stg_wb_addr[k]==of_src_addr[s]) & (of_src_addr[s]!=0).
REQ-023 Winner SHALL be lowest-index matching stage (youngest priority); x0 never matches.
REQ-024 hz SHALL assert if any source's winner has stg_data_ready=0, or any used source has no match and pending[addr]=1.
REQ-025 stall SHALL be: if = hz|~dmem_ready; ifof = hz|~dmem_ready|~imem_ready; ofex = exmem = memwb = ~dmem_ready.
REQ-026 fwd_data/fwd_en SHALL update only when dmem_ready=1: with hz=0, fwd_en[s]<=winner exists, fwd_data[s]<=winner data; with no winner fwd_data holds; with hz=1 all fwd_en<=0 (bubble).
REQ-027 Scoreboard pending[31:1] SHALL set on ld_issue (rd!=0) and clear on ld_done; same-cycle same-rd issue and done SHALL leave bit set.
REQ-028 Outstanding count SHALL +1 on ld_issue, -1 on ld_done, unchanged on both; ld_credit_ok = count < MAX_LD, combinational.
REQ-029 ld_issue with count==MAX_LD, or ld_done with count==0 (and no ld_issue), SHALL leave count unchanged and set sb_err.
REQ-030 hazard_stall_cnt SHALL increment each cycle hz=1 & dmem_ready=1, saturating at all-ones.
REQ-031 Forwarding result latency SHALL be 1 cycle from OF inputs to fwd_data/fwd_en.
Reset
REQ-032 On reset: fwd_data=0, fwd_en=0, pending=0, count=0, hazard_stall_cnt=0, sb_err=0, immediately and asynchronously; reset mid-load SHALL discard all pending state.
REQ-033 Combinational stall and ld_credit_ok SHALL reflect reset state (ld_credit_ok=1) while reset is asserted.
Structure
REQ-034 Stall-vector bit indices, NOP constant and default parameter values SHALL live in rv32_pkg.
REQ-035 Scoreboard plus outstanding counter SHALL be sub-module ld_scoreboard; matching/priority SHALL be generate loops, no casex tables.
Verification
REQ-036 src0=x5, stg1 wb x5 data 0xAA, stg2 wb x5 data 0xBB, ready -> next cycle fwd_en[0]=1, fwd_data[0]=0xAA.
REQ-037 src0=src1=x0, all stages write x0 -> fwd_en=0, no stall.
REQ-038 stg0 wb x7 data_ready=0, src1=x7 -> stall[if]=stall[ifof]=1, fwd_en<=0, hazard_stall_cnt +1.
REQ-039 ld_issue rd=x9, no stage match, src0=x9 -> hz=1 until ld_done rd=x9, then stall clears next cycle.
REQ-040 MAX_LD=4: 4 ld_issue -> ld_credit_ok=0; 5th issue -> sb_err=1, count stays 4; reset -> all cleared.
REQ-041 dmem_ready=0 with matches -> stall=5'b11111, fwd outputs hold.
